seven_seg_scan: RTL

//  Time-multiplexed driver for N_DIGITS seven-segment digits with an internal

---
 rtl/seven_seg_pkg.sv | 45 ++++
 rtl/seven_seg_scan_if.sv | 26 ++
 rtl/seven_seg_decode.sv | 10 +
 rtl/seven_seg_scan.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Segment code constants and hex-to-segment mapping shared by the scan driver.
// Codes are active-high, bit0 = segment a .. bit6 = segment g.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h58;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle: value/attribute inputs from register logic, pin-level outputs back.
// master = register/display logic, slave = scan driver.
interface seven_seg_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int BRIGHT_W = 3
);
    logic [4*N_DIGITS-1:0] d;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lzs;
    logic [BRIGHT_W-1:0]   bright;
    logic [N_DIGITS-1:0]   dig_sel;
    logic [6:0]            seg;
    logic                  dp_out;
    logic                  frame_start;

    modport master (
        output d, dp, blank, lzs, bright,
        input  dig_sel, seg, dp_out, frame_start
    );

    modport slave (
        input  d, dp, blank, lzs, bright,
        output dig_sel, seg, dp_out, frame_start
    );
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational nibble to active-high 7-segment code.
// Zero latency, no flow control.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    assign o_seg = hex_to_seg(i_nibble);
endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with frame-coherent capture, blanking, LZS, PWM and guard.
// Outputs registered one cycle after the prescaler/digit index; no backpressure, free-running scan.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIV_LOG2     = 10,
    parameter int BRIGHT_W     = 3,
    parameter int GUARD        = 2,
    parameter bit SEG_ACT_HIGH = 1'b1,
    parameter bit DIG_ACT_HIGH = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    seven_seg_scan_if.slave bus
);
    localparam int                  IDX_W   = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]    LAST    = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF = DIG_ACT_HIGH ? '0 : '1;
    localparam logic [6:0]          SEG_OFF = SEG_ACT_HIGH ? 7'h00 : 7'h7F;
    localparam logic                DP_OFF  = !SEG_ACT_HIGH;

    logic [DIV_LOG2-1:0]   r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_d;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_blank;
    logic                  r_lzs;
    logic [BRIGHT_W-1:0]   r_bright;
    logic [N_DIGITS-1:0]   r_dig_sel;
    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [N_DIGITS-1:0]   w_supp;
    logic [3:0]            w_nibble;
    logic [6:0]            w_code;
    logic [BRIGHT_W-1:0]   w_phase;
    logic                  w_pwm;
    logic                  w_guard;
    logic                  w_on;
    logic                  w_lit;
    logic [N_DIGITS-1:0]   w_dig;
    logic [6:0]            w_seg;
    logic                  w_dp;

    assign w_tick      = &r_cnt;
    assign w_frame_end = w_tick && (r_idx == LAST);

    // Shadows only move at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_d           <= '0;
            r_dp          <= '0;
            r_blank       <= '0;
            r_lzs         <= 1'b0;
            r_bright      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + DIV_LOG2'(1);
            r_frame_start <= w_frame_end;
            if (w_tick) begin
                r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
            end
            if (w_frame_end) begin
                r_d      <= bus.d;
                r_dp     <= bus.dp;
                r_blank  <= bus.blank;
                r_lzs    <= bus.lzs;
                r_bright <= bus.bright;
            end
        end
    end

    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        w_supp = '0;
        w_supp[N_DIGITS-1] = r_lzs && (r_d[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int k = N_DIGITS - 2; k >= 1; k--) begin
            w_supp[k] = w_supp[k+1] && (r_d[4*k +: 4] == 4'h0);
        end
        w_supp[0] = 1'b0;
    end

    assign w_nibble = r_d[4*r_idx +: 4];

    seven_seg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_code)
    );

    assign w_phase = r_cnt[DIV_LOG2-1 -: BRIGHT_W];
    assign w_pwm   = (&r_bright) || (w_phase < r_bright);
    assign w_guard = r_cnt < DIV_LOG2'(GUARD);
    assign w_on    = !w_guard && w_pwm;
    assign w_lit   = w_on && !r_blank[r_idx];
    assign w_dig   = w_on ? (N_DIGITS'(1) << r_idx) : '0;
    assign w_seg   = (w_lit && !w_supp[r_idx]) ? w_code : 7'h00;
    assign w_dp    = w_lit && r_dp[r_idx];

    // XOR with the inactive level applies polarity and keeps dark cycles at the non-lit level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_sel <= DIG_OFF;
            r_seg     <= SEG_OFF;
            r_dp_out  <= DP_OFF;
        end else begin
            r_dig_sel <= w_dig ^ DIG_OFF;
            r_seg     <= w_seg ^ SEG_OFF;
            r_dp_out  <= w_dp ^ DP_OFF;
        end
    end

    assign bus.dig_sel     = r_dig_sel;
    assign bus.seg         = r_seg;
    assign bus.dp_out      = r_dp_out;
    assign bus.frame_start = r_frame_start;

endmodule
